// File: rtl/wb_pkg.sv
// Shared types for the MEM/WB pipeline stage: FSM state encoding and writeback control bundle.
package wb_pkg;

    typedef enum logic [1:0] {WB_EMPTY, WB_BUSY, WB_FULL} wb_state_e;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mult_start;
    } wb_ctrl_t;

endpackage

// File: rtl/wb_pipe_stage.sv
// Elastic MEM/WB pipeline stage with valid/ready handshake, optional 2-entry skid buffer and flush.
// Also produces the selected writeback value and a forwarding-enable for the hazard unit.
module wb_pipe_stage
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_W   = 5,
    parameter int unsigned SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_reg_write,
    input  logic              in_mem_to_reg,
    input  logic              in_mult_start,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_mem_data,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_reg_write,
    output logic              out_mem_to_reg,
    output logic              out_mult_start,
    output logic [DATA_W-1:0] out_wb_data,
    output logic              fwd_en
);

    typedef struct packed {
        logic [DATA_W-1:0] mem_data;
        logic [DATA_W-1:0] alu_result;
        logic [RD_W-1:0]   rd;
        wb_ctrl_t          ctrl;
    } slot_t;

    slot_t in_slot;
    slot_t head;
    logic  head_valid;
    logic  in_fire;
    logic  out_fire;

    assign in_slot.mem_data        = in_mem_data;
    assign in_slot.alu_result      = in_alu_result;
    assign in_slot.rd              = in_rd;
    assign in_slot.ctrl.reg_write  = in_reg_write;
    assign in_slot.ctrl.mem_to_reg = in_mem_to_reg;
    assign in_slot.ctrl.mult_start = in_mult_start;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = head_valid & out_ready;

    if (SKID != 0) begin : g_skid
        wb_state_e state_q, state_d;
        slot_t     m_q, m_d;
        slot_t     s_q, s_d;

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= WB_EMPTY;
                m_q     <= '0;
                s_q     <= '0;
            end else begin
                state_q <= state_d;
                m_q     <= m_d;
                s_q     <= s_d;
            end
        end

        // Main slot M always feeds the output; S only catches the one entry accepted during a stall.
        always_comb begin
            state_d = state_q;
            m_d     = m_q;
            s_d     = s_q;
            if (flush) begin
                state_d = WB_EMPTY;
                m_d     = '0;
                s_d     = '0;
            end else begin
                case (state_q)
                    WB_EMPTY: begin
                        if (in_fire) begin
                            m_d     = in_slot;
                            state_d = WB_BUSY;
                        end
                    end
                    WB_BUSY: begin
                        if (in_fire && out_fire) begin
                            m_d = in_slot;
                        end else if (in_fire) begin
                            s_d     = in_slot;
                            state_d = WB_FULL;
                        end else if (out_fire) begin
                            state_d = WB_EMPTY;
                        end
                    end
                    WB_FULL: begin
                        if (out_fire) begin
                            m_d     = s_q;
                            state_d = WB_BUSY;
                        end
                    end
                    default: state_d = WB_EMPTY;
                endcase
            end
        end

        // Decoded from the state register alone, so no out_ready -> in_ready path exists.
        assign in_ready   = (state_q != WB_FULL);
        assign head_valid = (state_q != WB_EMPTY);
        assign head       = m_q;
    end else begin : g_single
        logic  valid_q, valid_d;
        slot_t m_q, m_d;

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                m_q     <= '0;
            end else begin
                valid_q <= valid_d;
                m_q     <= m_d;
            end
        end

        always_comb begin
            valid_d = valid_q;
            m_d     = m_q;
            if (flush) begin
                valid_d = 1'b0;
                m_d     = '0;
            end else if (in_fire) begin
                valid_d = 1'b1;
                m_d     = in_slot;
            end else if (out_fire) begin
                valid_d = 1'b0;
            end
        end

        assign in_ready   = ~valid_q | out_ready;
        assign head_valid = valid_q;
        assign head       = m_q;
    end

    assign out_valid      = head_valid;
    assign out_mem_data   = head.mem_data;
    assign out_alu_result = head.alu_result;
    assign out_rd         = head.rd;
    assign out_reg_write  = head_valid & head.ctrl.reg_write;
    assign out_mem_to_reg = head_valid & head.ctrl.mem_to_reg;
    assign out_mult_start = head_valid & head.ctrl.mult_start;

    assign out_wb_data = out_mem_to_reg ? out_mem_data : out_alu_result;
    assign fwd_en      = out_valid & out_reg_write & (out_rd != '0);

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Bench for wb_pipe_stage: SKID=1 and SKID=0 instances driven in lockstep, each checked against a queue model.
module tb_wb_pipe_stage;

    typedef struct packed {
        logic [31:0] mem;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        rw;
        logic        m2r;
        logic        ms;
    } entry_t;

    logic   clk;
    logic   rst;
    logic   flush;
    logic   in_valid;
    logic   out_ready;
    entry_t cur;

    logic        o1_in_ready, o1_out_valid, o1_rw, o1_m2r, o1_ms, o1_fwd;
    logic [31:0] o1_md, o1_alu, o1_wb;
    logic [4:0]  o1_rd;
    logic        o0_in_ready, o0_out_valid, o0_rw, o0_m2r, o0_ms, o0_fwd;
    logic [31:0] o0_md, o0_alu, o0_wb;
    logic [4:0]  o0_rd;

    int checks = 0;
    int errors = 0;

    entry_t q1[$];
    entry_t q0[$];
    bit     z1 = 1'b1;
    bit     z0 = 1'b1;
    bit     chk_en = 1'b0;

    wb_pipe_stage #(.DATA_W(32), .RD_W(5), .SKID(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(o1_in_ready),
        .in_mem_data(cur.mem), .in_alu_result(cur.alu), .in_rd(cur.rd),
        .in_reg_write(cur.rw), .in_mem_to_reg(cur.m2r), .in_mult_start(cur.ms),
        .out_valid(o1_out_valid), .out_ready(out_ready),
        .out_mem_data(o1_md), .out_alu_result(o1_alu), .out_rd(o1_rd),
        .out_reg_write(o1_rw), .out_mem_to_reg(o1_m2r), .out_mult_start(o1_ms),
        .out_wb_data(o1_wb), .fwd_en(o1_fwd)
    );

    wb_pipe_stage #(.DATA_W(32), .RD_W(5), .SKID(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(o0_in_ready),
        .in_mem_data(cur.mem), .in_alu_result(cur.alu), .in_rd(cur.rd),
        .in_reg_write(cur.rw), .in_mem_to_reg(cur.m2r), .in_mult_start(cur.ms),
        .out_valid(o0_out_valid), .out_ready(out_ready),
        .out_mem_data(o0_md), .out_alu_result(o0_alu), .out_rd(o0_rd),
        .out_reg_write(o0_rw), .out_mem_to_reg(o0_m2r), .out_mult_start(o0_ms),
        .out_wb_data(o0_wb), .fwd_en(o0_fwd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic check_dut(input string t, input int sz, input entry_t h, input bit z, input bit er,
                             input logic rdy, input logic vld, input logic [31:0] md,
                             input logic [31:0] alu, input logic [4:0] rd, input logic rw,
                             input logic m2r, input logic ms, input logic [31:0] wb, input logic fwd);
        chk({t, "_in_ready"}, 64'(rdy), 64'(er));
        chk({t, "_out_valid"}, 64'(vld), 64'(sz > 0));
        if (sz > 0) begin
            chk({t, "_mem_data"}, 64'(md), 64'(h.mem));
            chk({t, "_alu_result"}, 64'(alu), 64'(h.alu));
            chk({t, "_rd"}, 64'(rd), 64'(h.rd));
            chk({t, "_ctrl"}, 64'({rw, m2r, ms}), 64'({h.rw, h.m2r, h.ms}));
            chk({t, "_wb_data"}, 64'(wb), 64'(h.m2r ? h.mem : h.alu));
            chk({t, "_fwd_en"}, 64'(fwd), 64'(h.rw && (h.rd != 5'd0)));
        end else begin
            chk({t, "_idle_ctrl"}, 64'({rw, m2r, ms, fwd}), 64'(0));
            if (z) begin
                chk({t, "_cleared_payload"}, 64'({md, rd}), 64'(0));
                chk({t, "_cleared_alu_wb"}, 64'({alu, wb}), 64'(0));
            end
        end
    endtask

    // One cycle: check settled outputs against the model, advance the model, cross the clock edge.
    task automatic tick();
        bit     er1, er0;
        entry_t h1, h0;
        #2;
        er1 = (q1.size() < 2);
        er0 = (q0.size() == 0) || out_ready;
        if (chk_en) begin
            h1 = (q1.size() > 0) ? q1[0] : '0;
            h0 = (q0.size() > 0) ? q0[0] : '0;
            check_dut("skid1", q1.size(), h1, z1, er1, o1_in_ready, o1_out_valid, o1_md, o1_alu,
                      o1_rd, o1_rw, o1_m2r, o1_ms, o1_wb, o1_fwd);
            check_dut("skid0", q0.size(), h0, z0, er0, o0_in_ready, o0_out_valid, o0_md, o0_alu,
                      o0_rd, o0_rw, o0_m2r, o0_ms, o0_wb, o0_fwd);
        end
        if (rst || flush) begin
            q1.delete();
            q0.delete();
            z1 = 1'b1;
            z0 = 1'b1;
        end else begin
            if (q1.size() > 0 && out_ready) void'(q1.pop_front());
            if (in_valid && er1) begin
                q1.push_back(cur);
                z1 = 1'b0;
            end
            if (q0.size() > 0 && out_ready) void'(q0.pop_front());
            if (in_valid && er0) begin
                q0.push_back(cur);
                z0 = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk_en = 1'b1;
    endtask

    function automatic entry_t rand_entry();
        entry_t e;
        e.mem = $urandom;
        e.alu = $urandom;
        e.rd  = 5'($urandom_range(0, 31));
        e.rw  = 1'($urandom_range(0, 1));
        e.m2r = 1'($urandom_range(0, 1));
        e.ms  = 1'($urandom_range(0, 1));
        return e;
    endfunction

    function automatic entry_t mk(input logic [31:0] mem, input logic [31:0] alu, input logic [4:0] rd,
                                  input logic rw, input logic m2r);
        entry_t e;
        e.mem = mem;
        e.alu = alu;
        e.rd  = rd;
        e.rw  = rw;
        e.m2r = m2r;
        e.ms  = 1'b0;
        return e;
    endfunction

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cur       = '0;
        tick();
        rst = 1'b0;
        tick();

        // Streaming: four back-to-back entries with the sink always ready
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            cur = mk(32'h0, 32'((i + 1) * 32'h11), 5'(i + 1), 1'b1, 1'b0);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();

        // Back-pressure: A accepted, sink stalls while A is shown, B goes to the skid slot
        in_valid = 1'b1;
        cur = mk(32'h0, 32'hA, 5'd1, 1'b1, 1'b0);
        tick();
        out_ready = 1'b0;
        cur = mk(32'h0, 32'hB, 5'd2, 1'b1, 1'b0);
        tick();
        chk("bp_full_in_ready", 64'(o1_in_ready), 64'(0));
        chk("bp_hold_A", 64'(o1_alu), 64'(32'hA));
        cur = mk(32'h0, 32'hC, 5'd3, 1'b1, 1'b0);
        tick();
        chk("bp_still_A", 64'(o1_alu), 64'(32'hA));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_B_next", 64'(o1_alu), 64'(32'hB));
        chk("bp_ready_with_B", 64'(o1_in_ready), 64'(1));
        tick();
        tick();

        // Writeback mux and forwarding
        in_valid = 1'b1;
        cur = mk(32'hDEADBEEF, 32'h5, 5'd7, 1'b1, 1'b1);
        tick();
        chk("wb_mux_mem", 64'(o1_wb), 64'(32'hDEADBEEF));
        chk("fwd_rd7", 64'(o1_fwd), 64'(1));
        cur = mk(32'hDEADBEEF, 32'h5, 5'd0, 1'b1, 1'b1);
        tick();
        chk("fwd_rd0", 64'(o1_fwd), 64'(0));
        in_valid = 1'b0;
        tick();

        // Flush colliding with out_fire and in_fire while FULL
        out_ready = 1'b0;
        in_valid  = 1'b1;
        cur = rand_entry();
        tick();
        cur = rand_entry();
        tick();
        flush     = 1'b1;
        out_ready = 1'b1;
        cur = rand_entry();
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", 64'(o1_out_valid), 64'(0));
        chk("flush_in_ready", 64'(o1_in_ready), 64'(1));
        chk("flush_alu", 64'(o1_alu), 64'(0));
        tick();
        in_valid = 1'b1;
        cur = mk(32'h1234, 32'h77, 5'd9, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();

        // Reset while FULL with in_valid high
        out_ready = 1'b0;
        in_valid  = 1'b1;
        cur = rand_entry();
        tick();
        cur = rand_entry();
        tick();
        rst = 1'b1;
        cur = rand_entry();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", 64'(o1_in_ready), 64'(1));
        chk("rst_outputs", 64'({o1_out_valid, o1_fwd, o1_rw, o1_alu}), 64'(0));
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cur = rand_entry();
            tick();
        end
        in_valid = 1'b0;
        tick();

        // out_ready toggling with in_valid held high (exercises the combinational in_ready path)
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            out_ready = (i % 3) != 1;
            cur = mk(32'h0, 32'h100 + 32'(i), 5'd4, 1'b1, 1'b0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            rst       = ($urandom_range(0, 63) == 0);
            cur       = rand_entry();
            tick();
        end
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_pipe_stage.md
# wb_pipe_stage

Parametrised, elastic MEM/WB pipeline stage. Carries load data, ALU result, destination register and writeback control from the memory stage to the register-file writeback, with a valid/ready handshake, a 2-entry skid buffer for back-pressure, and a synchronous flush. It also produces the selected writeback value and a forwarding-enable for the hazard unit. It replaces the fixed always-advance MEM/WB register in the RV32IM core.

## Interface
Parameters:
- DATA_W, 32, width of mem_data / alu_result / wb_data
- RD_W, 5, destination register index width
- SKID, 1, 1 = 2-entry skid buffer (registered in_ready); 0 = single register, combinational in_ready

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  synchronous invalidate of all held entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept this cycle
- in_mem_data  in  DATA_W  load data
- in_alu_result  in  DATA_W  ALU/MUL result
- in_rd  in  RD_W  destination register
- in_reg_write  in  1  writeback enable
- in_mem_to_reg  in  1  select mem_data for writeback
- in_mult_start  in  1  multiplier-start marker
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream accepts
- out_mem_data, out_alu_result  out  DATA_W  held payload
- out_rd  out  RD_W  held destination
- out_reg_write, out_mem_to_reg, out_mult_start  out  1  held control, each forced 0 when out_valid=0
- out_wb_data  out  DATA_W  out_mem_to_reg ? out_mem_data : out_alu_result
- fwd_en  out  1  out_valid & out_reg_write & (out_rd != 0)

## Operation
- Transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- SKID=1 FSM (main slot M, skid slot S):
  - EMPTY: out_valid=0, in_ready=1. in_fire -> load M, go BUSY.
  - BUSY: out_valid=1, in_ready=1. in_fire & out_fire -> load M, stay BUSY. in_fire & !out_fire -> load S, go FULL. !in_fire & out_fire -> EMPTY. Otherwise hold.
  - FULL: out_valid=1, in_ready=0. out_fire -> M <= S, go BUSY. Otherwise hold.
  - in_ready is a function of the state register only; it has no combinational path from out_ready.
- SKID=0: a single slot. in_ready = !out_valid | out_ready (combinational). in_fire loads the slot. out_fire & !in_fire clears valid.
- Ordering is strict FIFO. No entry is dropped or duplicated except by flush or rst.
- Output payload must be stable while out_valid & !out_ready.
- flush: next state is EMPTY and all slots are invalidated. Flush has priority over a simultaneous in_fire or out_fire; the incoming entry is discarded. Payload registers are cleared to 0.
- rst: same effect as flush. All outputs reset to 0, except in_ready, which is 1 from the first cycle after reset (state EMPTY).
- in_valid is ignored while rst=1.

## Timing
- Latency: in_fire at edge N -> out_valid=1 with that payload after edge N, visible in cycle N+1.
- Throughput: 1 entry/cycle while out_ready=1, in both modes.
- Back-pressure (SKID=1): if out_ready drops, at most one more entry is accepted (into S). in_ready falls on the following cycle.
- After out_ready re-asserts in FULL: S is presented the next cycle, and in_ready=1 that same cycle.
- out_wb_data and fwd_en are combinational from the output registers. They add no latency.
- Flush asserted in cycle N: out_valid=0 and fwd_en=0 from cycle N+1.

## Structure
- Shared package wb_pkg holds:
  - typedef enum logic [1:0] {WB_EMPTY, WB_BUSY, WB_FULL} wb_state_e
  - typedef struct packed {reg_write, mem_to_reg, mult_start} wb_ctrl_t
- The payload is packed into one struct per slot so that M and S copy as a unit.
- There is no sub-module. SKID is selected with a generate-if in a single file.

## Test plan
- Streaming (SKID=1): out_ready=1, 4 back-to-back entries, alu_result 0x11..0x44 -> out_valid from cycle 1, values appear in order one per cycle, in_ready stays 1.
- Back-pressure: entries A=0xA, B=0xB accepted; out_ready=0 from A's output cycle -> state FULL, in_ready=0, A held stable. Release out_ready -> A then B output, in_ready=1 the cycle B is presented.
- Writeback mux/forward: mem_to_reg=1, mem_data=0xDEADBEEF, alu=0x5, rd=7, reg_write=1 -> out_wb_data=0xDEADBEEF, fwd_en=1. Repeat with rd=0 -> fwd_en=0.
- Flush collision: state FULL, flush=1 together with out_ready=1 -> next cycle out_valid=0, in_ready=1, all outputs 0. A new entry accepted afterwards appears normally.
- Reset mid-operation: rst asserted in FULL with in_valid=1 -> after the edge all outputs 0, in_ready=1. The first entry accepted after reset is the first one output.
- SKID=0: out_ready toggling 1,0,1 with in_valid held at 1 -> in_ready follows !out_valid|out_ready combinationally, no entry lost or repeated.
